// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg: state encoding, ASCII constants and hex decode shared by the UART command register file.
package uart_cmd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GET_IDX,
        ST_GET_BITS,
        ST_COMMIT,
        ST_SEND_BITS,
        ST_SEND_ACK,
        ST_SEND_ERR
    } state_t;

    localparam logic [7:0] CH_ACK      = 8'h2A;
    localparam logic [7:0] CH_ERR      = 8'h21;
    localparam logic [7:0] CH_RST      = 8'h52;
    localparam logic [7:0] CH_0        = 8'h30;
    localparam logic [7:0] CH_1        = 8'h31;
    localparam logic [7:0] CH_SET      = 8'h53;
    localparam logic [7:0] CH_GET      = 8'h47;
    localparam logic [7:0] CH_PULSE    = 8'h50;
    localparam logic [7:0] CH_ECHO_ON  = 8'h45;
    localparam logic [7:0] CH_ECHO_OFF = 8'h65;

    // {valid, nibble}; only '0'-'9' and uppercase 'A'-'F' are accepted
    function automatic logic [4:0] hex_nib(input logic [7:0] c);
        return (c >= 8'h30 && c <= 8'h39) ? {1'b1, 4'(c - 8'h30)} :
               (c >= 8'h41 && c <= 8'h46) ? {1'b1, 4'(c - 8'h37)} : 5'd0;
    endfunction

endpackage

// File: rtl/uart_tx_holdreg.sv
// uart_tx_holdreg: single-entry valid/ready byte buffer feeding the UART transmitter.
module uart_tx_holdreg (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_i,
    input  logic [7:0] data_i,
    input  logic       ready_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    output logic       busy_o
);
    logic [7:0] data_q;
    logic       valid_q;

    // busy while occupied, including the accept cycle, so a new byte loads the cycle after
    assign busy_o  = valid_q;
    assign data_o  = data_q;
    assign valid_o = valid_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else if (load_i && !valid_q) begin
            data_q  <= data_i;
            valid_q <= 1'b1;
        end else if (valid_q && ready_i) begin
            valid_q <= 1'b0;
        end
    end
endmodule

// File: rtl/uart_cmd_regfile.sv
// uart_cmd_regfile: ASCII command parser driving NUM_REGS x REG_WIDTH control registers over a UART byte stream.
module uart_cmd_regfile
    import uart_cmd_pkg::*;
#(
    parameter int                             NUM_REGS       = 4,
    parameter int                             REG_WIDTH      = 8,
    parameter logic [NUM_REGS*REG_WIDTH-1:0]  RESET_VALUE    = '0,
    parameter int unsigned                    TIMEOUT_CYCLES = 1000000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    rx_data,
    input  logic                          rx_valid,
    output logic [7:0]                    tx_data,
    output logic                          tx_valid,
    input  logic                          tx_ready,
    output logic [NUM_REGS*REG_WIDTH-1:0] reg_q,
    output logic [NUM_REGS-1:0]           reg_wr_stb,
    output logic [NUM_REGS-1:0]           cmd_stb,
    output logic                          echo_en,
    output logic                          overrun
);
    localparam int              IW       = NUM_REGS > 1 ? $clog2(NUM_REGS) : 1;
    localparam int              CW       = $clog2(REG_WIDTH + 1);
    localparam logic [CW-1:0]   LAST_BIT = CW'(REG_WIDTH - 1);
    localparam logic [4:0]      NREG     = 5'(NUM_REGS);
    localparam logic [31:0]     TO_LAST  = 32'(TIMEOUT_CYCLES - 1);

    state_t                             state_q;
    logic [NUM_REGS-1:0][REG_WIDTH-1:0] regs_q;
    logic [REG_WIDTH-1:0]               shadow_q, shadow_d, snap_q;
    logic [IW-1:0]                      idx_q;
    logic [7:0]                         cmd_q;
    logic [CW-1:0]                      cnt_q;
    logic [31:0]                        tcnt_q;
    logic [NUM_REGS-1:0]                reg_wr_stb_q, cmd_stb_q;
    logic                               echo_en_q, overrun_q;
    logic                               busy, abort, echo_load, resp_load, idx_ok, bit_ok, timed_out;
    logic [7:0]                         resp_byte;
    logic [4:0]                         hex;

    assign reg_q      = regs_q;
    assign reg_wr_stb = reg_wr_stb_q;
    assign cmd_stb    = cmd_stb_q;
    assign echo_en    = echo_en_q;
    assign overrun    = overrun_q;

    assign hex       = hex_nib(rx_data);
    assign idx_ok    = hex[4] && ({1'b0, hex[3:0]} < NREG);
    assign bit_ok    = rx_data == CH_0 || rx_data == CH_1;
    assign shadow_d  = REG_WIDTH'({shadow_q, rx_data[0]});
    assign abort     = rx_valid && rx_data == CH_RST;
    assign timed_out = TIMEOUT_CYCLES != 0 && !rx_valid && tcnt_q == TO_LAST;
    // echo wins the holding register; a response byte simply waits a cycle
    assign echo_load = echo_en_q && rx_valid && !busy;
    assign resp_load = (state_q inside {ST_SEND_BITS, ST_SEND_ACK, ST_SEND_ERR}) && !busy && !echo_load && !abort;
    assign resp_byte = state_q == ST_SEND_ACK ? CH_ACK :
                       state_q == ST_SEND_ERR ? CH_ERR :
                       snap_q[REG_WIDTH-1]    ? CH_1   : CH_0;

    uart_tx_holdreg u_tx (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (echo_load || resp_load),
        .data_i  (echo_load ? rx_data : resp_byte),
        .ready_i (tx_ready),
        .data_o  (tx_data),
        .valid_o (tx_valid),
        .busy_o  (busy)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            regs_q       <= RESET_VALUE;
            shadow_q     <= '0;
            snap_q       <= '0;
            idx_q        <= '0;
            cmd_q        <= '0;
            cnt_q        <= '0;
            tcnt_q       <= '0;
            reg_wr_stb_q <= '0;
            cmd_stb_q    <= '0;
            echo_en_q    <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            reg_wr_stb_q <= '0;
            cmd_stb_q    <= '0;
            tcnt_q       <= '0;
            if (echo_en_q && rx_valid && busy) overrun_q <= 1'b1;
            if (abort) begin
                state_q   <= ST_IDLE;
                shadow_q  <= '0;
                cnt_q     <= '0;
                overrun_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: if (rx_valid) begin
                        if (rx_data inside {CH_SET, CH_GET, CH_PULSE}) begin
                            cmd_q   <= rx_data;
                            state_q <= ST_GET_IDX;
                        end
                        if (rx_data inside {CH_ECHO_ON, CH_ECHO_OFF}) begin
                            echo_en_q <= rx_data == CH_ECHO_ON;
                            state_q   <= ST_SEND_ACK;
                        end
                    end
                    ST_GET_IDX: if (rx_valid) begin
                        idx_q    <= hex[IW-1:0];
                        cnt_q    <= '0;
                        shadow_q <= '0;
                        snap_q   <= regs_q[hex[IW-1:0]];
                        state_q  <= !idx_ok ? ST_SEND_ERR :
                                    cmd_q == CH_SET ? ST_GET_BITS :
                                    cmd_q == CH_GET ? ST_SEND_BITS : ST_SEND_ACK;
                        if (idx_ok && cmd_q == CH_PULSE) cmd_stb_q[hex[IW-1:0]] <= 1'b1;
                    end else if (timed_out) state_q <= ST_SEND_ERR;
                    else tcnt_q <= tcnt_q + 32'd1;
                    ST_GET_BITS: if (rx_valid) begin
                        if (bit_ok) begin
                            shadow_q <= shadow_d;
                            cnt_q    <= cnt_q + 1'b1;
                            if (cnt_q == LAST_BIT) state_q <= ST_COMMIT;
                        end else state_q <= ST_SEND_ERR;
                    end else if (timed_out) state_q <= ST_SEND_ERR;
                    else tcnt_q <= tcnt_q + 32'd1;
                    ST_COMMIT: begin
                        regs_q[idx_q]       <= shadow_q;
                        reg_wr_stb_q[idx_q] <= 1'b1;
                        state_q             <= ST_SEND_ACK;
                    end
                    ST_SEND_BITS: if (resp_load) begin
                        snap_q <= snap_q << 1;
                        cnt_q  <= cnt_q + 1'b1;
                        if (cnt_q == LAST_BIT) state_q <= ST_SEND_ACK;
                    end
                    // ack/err leave as soon as the byte is taken into the holding register
                    ST_SEND_ACK, ST_SEND_ERR: if (resp_load) state_q <= ST_IDLE;
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_cmd_regfile.sv
// tb_uart_cmd_regfile: table-driven command vectors with a tx byte scoreboard, plus timeout/echo/reset sequences.
module tb_uart_cmd_regfile;
    localparam logic [31:0] RV = 32'h4433_2211;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0, tx_ready = 1'b1;
    logic [7:0]  tx_data;
    logic        tx_valid, echo_en, overrun;
    logic [31:0] reg_q;
    logic [3:0]  reg_wr_stb, cmd_stb;

    int          n_vec = 0, n_err = 0, rdy_mode = 0;
    logic [7:0]  exp_q[$];
    int          wr_cnt[4], cmd_cnt[4];
    logic [7:0]  wr_val[4], m[4];
    logic        hold_v = 1'b0;
    logic [7:0]  hold_d = '0;

    typedef struct {
        string      cmd;
        string      rsp;
        int         widx;
        logic [7:0] wval;
        logic [3:0] cmask;
        bit         rnd;
    } vec_t;
    vec_t vt[$];

    uart_cmd_regfile #(
        .NUM_REGS(4), .REG_WIDTH(8), .RESET_VALUE(RV), .TIMEOUT_CYCLES(100)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .reg_q(reg_q), .reg_wr_stb(reg_wr_stb), .cmd_stb(cmd_stb),
        .echo_en(echo_en), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        tx_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? 1'($urandom_range(0, 1)) : 1'b0;
    end

    // scoreboard monitor, sampled mid-cycle
    initial forever begin
        @(negedge clk);
        if (!rst_n) hold_v = 1'b0;
        else begin
            if (hold_v) check("tx_hold", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, hold_d});
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL tx_unexpected: got byte %0h, expected none", tx_data);
                end else check("tx_byte", tx_data, exp_q.pop_front());
            end
            hold_v = tx_valid && !tx_ready;
            hold_d = tx_data;
            for (int i = 0; i < 4; i++) begin
                if (reg_wr_stb[i]) begin
                    wr_cnt[i]++;
                    wr_val[i] = reg_q[i*8 +: 8];
                end
                if (cmd_stb[i]) cmd_cnt[i]++;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #1;
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic expect_str(input string s);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout: %0d bytes pending, expected 0", exp_q.size());
            exp_q.delete();
        end
        repeat (4) @(posedge clk);
    endtask

    function automatic logic [31:0] model_regs();
        return {m[3], m[2], m[1], m[0]};
    endfunction

    initial begin
        logic [15:0] got_wr, got_cmd, exp_wr, exp_cmd;
        for (int i = 0; i < 4; i++) m[i] = RV[i*8 +: 8];
        vt.push_back('{"S210100101", "*",          2, 8'hA5, 4'b0000, 1'b0});
        vt.push_back('{"G2",         "10100101*",  -1, 8'h00, 4'b0000, 1'b1});
        vt.push_back('{"S1101x",     "!",          -1, 8'h00, 4'b0000, 1'b0});
        vt.push_back('{"S7",         "!",          -1, 8'h00, 4'b0000, 1'b0});
        vt.push_back('{"P3",         "*",          -1, 8'h00, 4'b1000, 1'b0});
        vt.push_back('{"G0",         "00010001*",  -1, 8'h00, 4'b0000, 1'b1});
        vt.push_back('{"Ga",         "!",          -1, 8'h00, 4'b0000, 1'b0});
        vt.push_back('{"X",          "",           -1, 8'h00, 4'b0000, 1'b0});
        vt.push_back('{"S311110000", "*",          3, 8'hF0, 4'b0000, 1'b1});
        vt.push_back('{"G3",         "11110000*",  -1, 8'h00, 4'b0000, 1'b1});
        vt.push_back('{"PF",         "!",          -1, 8'h00, 4'b0000, 1'b0});
        vt.push_back('{"S0101R",     "",           -1, 8'h00, 4'b0000, 1'b0});
        vt.push_back('{"GR",         "",           -1, 8'h00, 4'b0000, 1'b0});
        vt.push_back('{"P0",         "*",          -1, 8'h00, 4'b0001, 1'b1});
        vt.push_back('{"S000000001", "*",          0, 8'h01, 4'b0000, 1'b0});
        vt.push_back('{"G1",         "00100010*",  -1, 8'h00, 4'b0000, 1'b0});

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_regs", reg_q, RV);
        check("rst_tx", {23'd0, tx_valid, tx_data}, 32'd0);
        check("rst_flags", {28'd0, echo_en, overrun, |reg_wr_stb, |cmd_stb}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        foreach (vt[k]) begin
            rdy_mode = vt[k].rnd ? 1 : 0;
            for (int i = 0; i < 4; i++) begin
                wr_cnt[i]  = 0;
                cmd_cnt[i] = 0;
            end
            expect_str(vt[k].rsp);
            send_str(vt[k].cmd);
            drain(300);
            if (vt[k].widx >= 0) m[vt[k].widx] = vt[k].wval;
            for (int i = 0; i < 4; i++) begin
                got_wr[i*4 +: 4]  = 4'(wr_cnt[i]);
                got_cmd[i*4 +: 4] = 4'(cmd_cnt[i]);
                exp_wr[i*4 +: 4]  = {3'd0, vt[k].widx == i};
                exp_cmd[i*4 +: 4] = {3'd0, vt[k].cmask[i]};
            end
            check({"regs_", vt[k].cmd}, reg_q, model_regs());
            check({"wr_stb_", vt[k].cmd}, {16'd0, got_wr}, {16'd0, exp_wr});
            check({"cmd_stb_", vt[k].cmd}, {16'd0, got_cmd}, {16'd0, exp_cmd});
            if (vt[k].widx >= 0) check({"wr_val_", vt[k].cmd}, wr_val[vt[k].widx], vt[k].wval);
        end

        // inter-character timeout inside a write
        rdy_mode = 0;
        expect_str("!");
        send_str("S010");
        repeat (95) @(posedge clk);
        @(negedge clk);
        check("timeout_early", {31'd0, tx_valid}, 32'd0);
        drain(40);
        check("timeout_regs", reg_q, model_regs());

        // echo with a stalled transmitter
        expect_str("*");
        send_str("E");
        drain(50);
        check("echo_on", {31'd0, echo_en}, 32'd1);
        rdy_mode = 2;
        repeat (2) @(posedge clk);
        expect_str("G");
        send_str("G0");
        @(negedge clk);
        check("overrun_set", {31'd0, overrun}, 32'd1);
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("echo_held", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, 8'h47});
        send_str("R");
        @(negedge clk);
        check("overrun_clr", {31'd0, overrun}, 32'd0);
        rdy_mode = 0;
        drain(50);
        expect_str("e*");
        send_str("e");
        drain(50);
        check("echo_off", {31'd0, echo_en}, 32'd0);

        // reset in the middle of a stalled readback
        expect_str("*");
        send_str("E");
        drain(50);
        rdy_mode = 2;
        repeat (2) @(posedge clk);
        send_str("G2");
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("pre_rst_valid", {31'd0, tx_valid}, 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_rst_tx", {23'd0, tx_valid, tx_data}, 32'd0);
        check("mid_rst_regs", reg_q, RV);
        check("mid_rst_flags", {30'd0, echo_en, overrun}, 32'd0);
        for (int i = 0; i < 4; i++) m[i] = RV[i*8 +: 8];
        rdy_mode = 0;
        expect_str("00110011*");
        send_str("G2");
        drain(100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end
endmodule
